// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and retire signal bundle for reorder_buffer.
// The master side is the pipeline and the slave side is the ROB.
interface reorder_buffer_if #(
   parameter int DEPTH        = 16,
   parameter int PREG_WIDTH   = 6,
   parameter int AREG_WIDTH   = 5,
   parameter int PC_WIDTH     = 12,
   parameter int COMMIT_WIDTH = 2
);
   localparam int IW = $clog2(DEPTH);

   logic                               disp_valid;
   logic                               disp_ready;
   logic [PC_WIDTH-1:0]                disp_pc;
   logic                               disp_reg_write;
   logic [AREG_WIDTH-1:0]              disp_rd_arch;
   logic [PREG_WIDTH-1:0]              disp_rd_new;
   logic [PREG_WIDTH-1:0]              disp_rd_old;
   logic [IW-1:0]                      disp_idx;

   logic                               wb_valid;
   logic [IW-1:0]                      wb_idx;
   logic                               wb_exc;

   logic [COMMIT_WIDTH-1:0]            cmt_valid;
   logic [COMMIT_WIDTH-1:0]            cmt_reg_write;
   logic [COMMIT_WIDTH*AREG_WIDTH-1:0] cmt_rd_arch;
   logic [COMMIT_WIDTH*PREG_WIDTH-1:0] cmt_rd_new;
   logic [COMMIT_WIDTH*PREG_WIDTH-1:0] cmt_free_reg;

   logic                               flush;
   logic [PC_WIDTH-1:0]                flush_pc;
   logic [IW:0]                        count;
   logic                               empty;
   logic                               full;

   modport master (
      output disp_valid, disp_pc, disp_reg_write, disp_rd_arch, disp_rd_new, disp_rd_old,
      output wb_valid, wb_idx, wb_exc,
      input  disp_ready, disp_idx,
      input  cmt_valid, cmt_reg_write, cmt_rd_arch, cmt_rd_new, cmt_free_reg,
      input  flush, flush_pc, count, empty, full
   );

   modport slave (
      input  disp_valid, disp_pc, disp_reg_write, disp_rd_arch, disp_rd_new, disp_rd_old,
      input  wb_valid, wb_idx, wb_exc,
      output disp_ready, disp_idx,
      output cmt_valid, cmt_reg_write, cmt_rd_arch, cmt_rd_new, cmt_free_reg,
      output flush, flush_pc, count, empty, full
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, marks completion by slot,
// retires up to COMMIT_WIDTH done entries per cycle, and flushes on a faulting head.
module reorder_buffer #(
   parameter int DEPTH        = 16,
   parameter int PREG_WIDTH   = 6,
   parameter int AREG_WIDTH   = 5,
   parameter int PC_WIDTH     = 12,
   parameter int COMMIT_WIDTH = 2
) (
   input logic             clk,
   input logic             rst,
   reorder_buffer_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam int CW = COMMIT_WIDTH;

   logic [PW-1:0]         head, tail;
   logic [DEPTH-1:0]      valid, done, exc;
   logic [PC_WIDTH-1:0]   pc_q   [DEPTH];
   logic [DEPTH-1:0]      rw_q;
   logic [AREG_WIDTH-1:0] arch_q [DEPTH];
   logic [PREG_WIDTH-1:0] new_q  [DEPTH];
   logic [PREG_WIDTH-1:0] old_q  [DEPTH];

   logic [IW-1:0]         hidx, tidx;
   logic                  full, head_fault, disp_fire, chain;
   logic [IW-1:0]         lane_idx [CW];
   logic [CW-1:0]         lane_ret;
   logic [PW-1:0]         n_ret;

   assign hidx           = head[IW-1:0];
   assign tidx           = tail[IW-1:0];
   assign full           = (hidx == tidx) && (head[IW] != tail[IW]);
   assign head_fault     = valid[hidx] & done[hidx] & exc[hidx];
   assign disp_fire      = bus.disp_valid & bus.disp_ready;

   assign bus.disp_ready = ~full & ~head_fault;
   assign bus.disp_idx   = tidx;
   assign bus.count      = tail - head;
   assign bus.empty      = (head == tail);
   assign bus.full       = full;

   // A lane retires only if every older lane in this cycle also retires.
   always_comb begin
      chain    = 1'b1;
      n_ret    = '0;
      lane_ret = '0;
      for (int unsigned k = 0; k < CW; k++) begin
         lane_idx[k] = hidx + IW'(k);
         chain       = chain & valid[lane_idx[k]] & done[lane_idx[k]] & ~exc[lane_idx[k]];
         lane_ret[k] = chain;
         n_ret       = n_ret + PW'(chain);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
         exc   <= '0;
      end else if (head_fault) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
         exc   <= '0;
      end else begin
         head <= head + n_ret;
         if (disp_fire)
            tail <= tail + PW'(1);
         if (bus.wb_valid && valid[bus.wb_idx]) begin
            done[bus.wb_idx] <= 1'b1;
            exc[bus.wb_idx]  <= bus.wb_exc;
         end
         for (int unsigned k = 0; k < CW; k++)
            if (lane_ret[k])
               valid[lane_idx[k]] <= 1'b0;
         // Tail slot is never a retiring slot, so allocation cannot collide with a clear.
         if (disp_fire) begin
            valid[tidx] <= 1'b1;
            done[tidx]  <= 1'b0;
            exc[tidx]   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (disp_fire) begin
         pc_q[tidx]   <= bus.disp_pc;
         rw_q[tidx]   <= bus.disp_reg_write;
         arch_q[tidx] <= bus.disp_rd_arch;
         new_q[tidx]  <= bus.disp_rd_new;
         old_q[tidx]  <= bus.disp_rd_old;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.cmt_valid     <= '0;
         bus.cmt_reg_write <= '0;
         bus.cmt_rd_arch   <= '0;
         bus.cmt_rd_new    <= '0;
         bus.cmt_free_reg  <= '0;
         bus.flush         <= 1'b0;
         bus.flush_pc      <= '0;
      end else begin
         bus.flush    <= head_fault;
         bus.flush_pc <= head_fault ? pc_q[hidx] : '0;
         for (int unsigned k = 0; k < CW; k++) begin
            bus.cmt_valid[k]     <= lane_ret[k];
            bus.cmt_reg_write[k] <= lane_ret[k] & rw_q[lane_idx[k]];
            bus.cmt_rd_arch[k*AREG_WIDTH +: AREG_WIDTH] <= lane_ret[k] ? arch_q[lane_idx[k]] : '0;
            bus.cmt_rd_new[k*PREG_WIDTH +: PREG_WIDTH]  <= lane_ret[k] ? new_q[lane_idx[k]]  : '0;
            bus.cmt_free_reg[k*PREG_WIDTH +: PREG_WIDTH] <= lane_ret[k] ? old_q[lane_idx[k]] : '0;
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based model of program order is
// compared against the DUT every cycle, plus hand-computed literal checkpoints.
module tb_reorder_buffer;
   localparam int DEPTH = 16;
   localparam int CW    = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   reorder_buffer_if #(.DEPTH(16), .PREG_WIDTH(6), .AREG_WIDTH(5), .PC_WIDTH(12), .COMMIT_WIDTH(2)) bus ();

   reorder_buffer #(.DEPTH(16), .PREG_WIDTH(6), .AREG_WIDTH(5), .PC_WIDTH(12), .COMMIT_WIDTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   // Model: entries in program order, oldest first; head_m is the slot of q[0].
   typedef struct {
      logic [11:0] pc;
      logic        rw;
      logic [4:0]  arch;
      logic [5:0]  nw;
      logic [5:0]  old;
      logic        dn;
      logic        ex;
   } ent_t;

   ent_t        q[$];
   int          head_m = 0;
   logic [1:0]  e_valid = '0;
   logic [1:0]  e_rw    = '0;
   logic [9:0]  e_arch  = '0;
   logic [11:0] e_new   = '0;
   logic [11:0] e_free  = '0;
   logic        e_flush = 1'b0;
   logic [11:0] e_fpc   = '0;

   always @(posedge clk or negedge rst) begin
      int   n;
      int   pos;
      logic rdy;
      ent_t e;
      if (!rst) begin
         q.delete();
         head_m  = 0;
         e_valid = '0; e_rw = '0; e_arch = '0; e_new = '0; e_free = '0;
         e_flush = 1'b0; e_fpc = '0;
      end else begin
         rdy = (q.size() < DEPTH) && !(q.size() > 0 && q[0].dn && q[0].ex);
         e_valid = '0; e_rw = '0; e_arch = '0; e_new = '0; e_free = '0;
         e_flush = 1'b0; e_fpc = '0;
         if (q.size() > 0 && q[0].dn && q[0].ex) begin
            e_flush = 1'b1;
            e_fpc   = q[0].pc;
            q.delete();
            head_m  = 0;
         end else begin
            n = 0;
            while (n < CW && n < q.size() && q[n].dn && !q[n].ex) begin
               e_valid[n]        = 1'b1;
               e_rw[n]           = q[n].rw;
               e_arch[n*5 +: 5]  = q[n].arch;
               e_new[n*6 +: 6]   = q[n].nw;
               e_free[n*6 +: 6]  = q[n].old;
               n++;
            end
            if (bus.wb_valid) begin
               pos = (int'(bus.wb_idx) - head_m + DEPTH) % DEPTH;
               if (pos < q.size()) begin
                  e    = q[pos];
                  e.dn = 1'b1;
                  e.ex = bus.wb_exc;
                  q[pos] = e;
               end
            end
            repeat (n) void'(q.pop_front());
            head_m = (head_m + n) % DEPTH;
            if (bus.disp_valid && rdy) begin
               e.pc   = bus.disp_pc;
               e.rw   = bus.disp_reg_write;
               e.arch = bus.disp_rd_arch;
               e.nw   = bus.disp_rd_new;
               e.old  = bus.disp_rd_old;
               e.dn   = 1'b0;
               e.ex   = 1'b0;
               q.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      int   sz;
      logic rdy;
      sz  = q.size();
      rdy = (sz < DEPTH) && !(sz > 0 && q[0].dn && q[0].ex);
      chk("cyc_disp_ready", bus.disp_ready, rdy);
      chk("cyc_disp_idx", bus.disp_idx, 64'((head_m + sz) % DEPTH));
      chk("cyc_count", bus.count, 64'(sz));
      chk("cyc_empty", bus.empty, sz == 0);
      chk("cyc_full", bus.full, sz == DEPTH);
      chk("cyc_cmt_valid", bus.cmt_valid, e_valid);
      chk("cyc_cmt_reg_write", bus.cmt_reg_write, e_rw);
      chk("cyc_cmt_rd_arch", bus.cmt_rd_arch, e_arch);
      chk("cyc_cmt_rd_new", bus.cmt_rd_new, e_new);
      chk("cyc_cmt_free_reg", bus.cmt_free_reg, e_free);
      chk("cyc_flush", bus.flush, e_flush);
      chk("cyc_flush_pc", bus.flush_pc, e_fpc);
   end

   task automatic step(input logic dv, input logic [11:0] pc, input logic [5:0] old,
                       input logic wv, input logic [3:0] wi, input logic we);
      bus.disp_valid     = dv;
      bus.disp_pc        = pc;
      bus.disp_reg_write = ~pc[2];
      bus.disp_rd_arch   = pc[6:2];
      bus.disp_rd_new    = pc[7:2] ^ 6'h2a;
      bus.disp_rd_old    = old;
      bus.wb_valid       = wv;
      bus.wb_idx         = wi;
      bus.wb_exc         = we;
      @(posedge clk);
      #1;
      bus.disp_valid = 1'b0;
      bus.wb_valid   = 1'b0;
      bus.wb_exc     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      chk("reset_count", bus.count, 0);
      chk("reset_ready", bus.disp_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      bus.disp_valid = 1'b0; bus.disp_pc = '0; bus.disp_reg_write = 1'b0;
      bus.disp_rd_arch = '0; bus.disp_rd_new = '0; bus.disp_rd_old = '0;
      bus.wb_valid = 1'b0; bus.wb_idx = '0; bus.wb_exc = 1'b0;
      #12;
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_ready", bus.disp_ready, 1);
      chk("rst_cmt_valid", bus.cmt_valid, 0);
      chk("rst_flush", bus.flush, 0);
      chk("rst_flush_pc", bus.flush_pc, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Fill, overflow attempt, partial drain, wrap-around reuse.
      for (int i = 0; i < 16; i++) begin
         chk("fill_idx", bus.disp_idx, 64'(i));
         step(1'b1, 12'(i * 4), 6'(i), 1'b0, '0, 1'b0);
      end
      chk("fill_full", bus.full, 1);
      chk("fill_ready", bus.disp_ready, 0);
      chk("fill_count", bus.count, 16);
      step(1'b1, 12'h3c0, 6'd63, 1'b0, '0, 1'b0);
      chk("overfill_count", bus.count, 16);
      for (int i = 0; i < 14; i++) step(1'b0, '0, '0, 1'b1, 4'(i), 1'b0);
      idle(2);
      chk("drain14_count", bus.count, 2);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_idx", bus.disp_idx, 64'(i));
         step(1'b1, 12'(32'h200 + i * 4), 6'(40 + i), 1'b0, '0, 1'b0);
      end
      chk("wrap_count", bus.count, 6);
      step(1'b0, '0, '0, 1'b1, 4'd14, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd15, 1'b0);
      idle(1);
      chk("span_cmt_valid", bus.cmt_valid, 2'b11);
      chk("span_free_reg", bus.cmt_free_reg, {6'd40, 6'd15});
      step(1'b1, 12'h210, 6'd44, 1'b1, 4'd1, 1'b0);
      step(1'b1, 12'h214, 6'd45, 1'b1, 4'd2, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd3, 1'b0);
      idle(4);
      chk("wrap_end_count", bus.count, 2);

      // Out-of-order completion, retire in order; writeback to an empty slot is dropped.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 12'(32'h080 + i * 4), 6'(20 + i), 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd5, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd2, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd1, 1'b0);
      chk("ooo_wait1", bus.cmt_valid, 0);
      step(1'b0, '0, '0, 1'b1, 4'd0, 1'b0);
      chk("ooo_wait2", bus.cmt_valid, 0);
      idle(1);
      chk("ooo_pair", bus.cmt_valid, 2'b11);
      chk("ooo_pair_count", bus.count, 1);
      idle(1);
      chk("ooo_single", bus.cmt_valid, 2'b01);
      idle(1);
      chk("ooo_done", bus.cmt_valid, 0);
      chk("ooo_empty", bus.empty, 1);
      for (int i = 3; i < 6; i++) step(1'b1, 12'(32'h090 + i * 4), 6'(i), 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd3, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd4, 1'b0);
      idle(3);
      chk("stale_wb_count", bus.count, 1);

      // Free-register report.
      do_reset();
      step(1'b1, 12'h100, 6'd9, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd0, 1'b0);
      idle(1);
      chk("free_valid", bus.cmt_valid, 2'b01);
      chk("free_rw", bus.cmt_reg_write, 2'b01);
      chk("free_reg", bus.cmt_free_reg, 12'd9);
      idle(1);
      chk("free_rw_pulse", bus.cmt_reg_write, 0);

      // Exception flush.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 12'(32'h040 + i * 4), 6'(i), 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd1, 1'b1);
      step(1'b0, '0, '0, 1'b1, 4'd0, 1'b0);
      idle(1);
      chk("exc_retire0", bus.cmt_valid, 2'b01);
      chk("exc_ready", bus.disp_ready, 0);
      chk("exc_noflush", bus.flush, 0);
      idle(1);
      chk("exc_flush", bus.flush, 1);
      chk("exc_flush_pc", bus.flush_pc, 12'h044);
      chk("exc_count", bus.count, 0);
      chk("exc_empty", bus.empty, 1);
      chk("exc_no_retire", bus.cmt_valid, 0);
      idle(1);
      chk("exc_pulse", bus.flush, 0);
      chk("exc_ready_after", bus.disp_ready, 1);
      chk("exc_idx_after", bus.disp_idx, 0);
      step(1'b1, 12'h300, 6'd1, 1'b0, '0, 1'b0);

      // Asynchronous reset with a retirement in flight.
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 12'(i * 8), 6'(i), 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd1, 1'b0);
      idle(1);
      chk("mid_count", bus.count, 7);
      chk("mid_cmt_valid", bus.cmt_valid, 2'b01);
      #2;
      rst = 1'b0;
      #1;
      chk("async_cmt_valid", bus.cmt_valid, 0);
      chk("async_count", bus.count, 0);
      chk("async_empty", bus.empty, 1);
      chk("async_full", bus.full, 0);
      chk("async_ready", bus.disp_ready, 1);
      chk("async_free_reg", bus.cmt_free_reg, 0);
      chk("async_flush", bus.flush, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("post_rst_cmt_valid", bus.cmt_valid, 0);
         chk("post_rst_count", bus.count, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count, power of two, at least 4; IW = log2(DEPTH).
REQ-002 SHALL have parameter PREG_WIDTH, default 6, physical tag width.
REQ-003 SHALL have parameter AREG_WIDTH, default 5, architectural register index width.
REQ-004 SHALL have parameter PC_WIDTH, default 12, PC width.
REQ-005 SHALL have parameter COMMIT_WIDTH, default 2, max retirements per cycle, legal values 1 or 2.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, as the following two lines define.
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 disp_valid  in  1  dispatch request.
REQ-010 disp_ready  out  1  dispatch accepted when high with disp_valid.
REQ-011 disp_pc  in  PC_WIDTH  instruction PC.
REQ-012 disp_reg_write  in  1  instruction writes rd.
REQ-013 disp_rd_arch  in  AREG_WIDTH  architectural rd.
REQ-014 disp_rd_new  in  PREG_WIDTH  newly allocated physical rd.
REQ-015 disp_rd_old  in  PREG_WIDTH  previous mapping of rd.
REQ-016 disp_idx  out  IW  slot allocated to the current dispatch (tail index).
REQ-017 wb_valid  in  1  completion report.
REQ-018 wb_idx  in  IW  completing slot.
REQ-019 wb_exc  in  1  completing instruction faulted.
REQ-020 cmt_valid  out  COMMIT_WIDTH  per-lane retire strobe; lane 0 is oldest.
REQ-021 cmt_reg_write, cmt_rd_arch, cmt_rd_new, cmt_free_reg  out  packed per lane  retire info; cmt_free_reg carries rd_old.
REQ-022 flush  out  1  one-cycle exception flush pulse.
REQ-023 flush_pc  out  PC_WIDTH  PC of faulting instruction.
REQ-024 count  out  IW+1  occupied entries; empty, full  out  1 each.

Function
REQ-025 SHALL use head/tail pointers of IW+1 bits with wrap bit; count = tail - head; empty when equal; full when indexes equal and wrap bits differ.
REQ-026 disp_ready SHALL be combinational: high when not full and head is not a done, excepting entry.
REQ-027 On disp_valid and disp_ready, SHALL write entry at tail with valid=1, done=0, exc=0, and advance tail by 1 at the edge.
REQ-028 Full SHALL be evaluated on pre-edge state; a same-cycle retirement does not allow dispatch into a full buffer.
REQ-029 On wb_valid, SHALL set done and latch exc for wb_idx if that entry is valid; writeback to an invalid slot SHALL be ignored.
REQ-030 At each edge, lane k SHALL retire entry head+k if it and all older lanes are valid, done and exc=0, up to COMMIT_WIDTH; head advances by the number retired.
REQ-031 Retire outputs SHALL be registered: visible in the cycle after the retiring edge, for exactly one cycle; unused lanes drive 0.
REQ-032 A writeback arriving in the same cycle as a retire decision SHALL take effect at that edge but be visible for retirement from the next edge.
REQ-033 When head is valid, done, exc=1: at the edge SHALL clear all valid bits, set head=tail=0, and register flush=1 with flush_pc = head PC next cycle; no lane retires.
REQ-034 Wrap-around SHALL be seamless; retire lanes spanning index DEPTH-1 to 0 SHALL retire in order.
REQ-035 Retirement and dispatch in the same cycle SHALL both occur; count reflects both.

Reset
REQ-036 While rst is low: pointers 0, all valid/done/exc cleared, cmt_valid=0, all cmt_* buses 0, flush=0, flush_pc=0, count=0, empty=1, full=0, disp_ready=1.
REQ-037 Reset asserted mid-operation SHALL discard all entries immediately and asynchronously.

Verification
REQ-038 Dispatch 16 entries back-to-back -> disp_idx 0..15, full=1, disp_ready=0 after 16th; 17th request not accepted, count stays 16.
REQ-039 Dispatch slots 0,1,2; writeback 2, then 1, then 0 -> nothing retires until slot 0 done; then cmt_valid=2'b11 (slots 0,1), next cycle 2'b01 (slot 2).
REQ-040 Slot 0 with reg_write=1, rd_old=6'd9 completes -> cmt_free_reg lane 0 = 9, cmt_reg_write=1 for one cycle.
REQ-041 Slots 0..3 dispatched, slot 1 completes with wb_exc=1 at PC 12'h044, slot 0 completes -> slot 0 retires, then flush=1, flush_pc=12'h044, count=0, empty=1.
REQ-042 Fill, retire 14, dispatch 4 more -> indexes 0,1 reused, retires across 15->0 in order, count correct throughout.
REQ-043 Assert rst low while count=7 and retire in flight -> outputs at REQ-036 values immediately, no cmt_valid after release.
